// File: rtl/boa_pmu_pkg.sv
// boa_pmu_pkg: shared state encoding for the power sequencer.
package boa_pmu_pkg;

   typedef enum logic [2:0] {PMU_RESET, PMU_RUN, PMU_SHDN, PMU_OFF, PMU_PWRUP} pmu_state_t;

endpackage

// File: rtl/pmu_bus.sv
// pmu_bus: reset/shutdown request lines from the PMU peripheral to the sequencer.
interface pmu_bus;

   logic rst;
   logic shdn;

   modport CPU (output rst, output shdn);
   modport PMU (input rst, input shdn);

endinterface

// File: rtl/boa_pmu_sequencer.sv
// boa_pmu_sequencer: turns PMU reset/shutdown requests and wake into a timed system reset and rail enable.
module boa_pmu_sequencer
   import boa_pmu_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int SHDN_CYCLES  = 64,
   parameter int PWRUP_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   pmu_bus.PMU  pmb,
   input  logic wake,
   output logic sys_rst,
   output logic pwr_en,
   output logic off
);

   localparam int MAX_A = (RST_CYCLES > SHDN_CYCLES) ? RST_CYCLES : SHDN_CYCLES;
   localparam int MAX_C = (MAX_A > PWRUP_CYCLES) ? MAX_A : PWRUP_CYCLES;
   localparam int CW    = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] RST_LD   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] SHDN_LD  = CW'(SHDN_CYCLES - 1);
   localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYCLES - 1);

   pmu_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_zero;

   assign cnt_zero = cnt_q == '0;

   // shutdown is checked before reset so a simultaneous request always powers down
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         PMU_RESET: begin
            if (pmb.shdn) begin
               state_d = PMU_SHDN;
               cnt_d   = SHDN_LD;
            end else if (pmb.rst) begin
               cnt_d   = RST_LD;
            end else if (cnt_zero) begin
               state_d = PMU_RUN;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end
         PMU_RUN: begin
            if (pmb.shdn) begin
               state_d = PMU_SHDN;
               cnt_d   = SHDN_LD;
            end else if (pmb.rst) begin
               state_d = PMU_RESET;
               cnt_d   = RST_LD;
            end
         end
         PMU_SHDN: begin
            if (cnt_zero) state_d = PMU_OFF;
            else cnt_d = cnt_q - 1'b1;
         end
         PMU_OFF: begin
            if (wake) begin
               state_d = PMU_PWRUP;
               cnt_d   = PWRUP_LD;
            end
         end
         PMU_PWRUP: begin
            if (cnt_zero) begin
               state_d = PMU_RESET;
               cnt_d   = RST_LD;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = PMU_RESET;
            cnt_d   = RST_LD;
         end
      endcase
   end

   // outputs decode the next state so they come straight from flops with no extra latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PMU_RESET;
         cnt_q   <= RST_LD;
         sys_rst <= 1'b1;
         pwr_en  <= 1'b1;
         off     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sys_rst <= state_d != PMU_RUN;
         pwr_en  <= state_d != PMU_OFF;
         off     <= state_d == PMU_OFF;
      end
   end

endmodule

// File: tb/tb_boa_pmu_sequencer.sv
// tb_boa_pmu_sequencer: directed vectors with a queued scoreboard checking {sys_rst,pwr_en,off}.
module tb_boa_pmu_sequencer;

   typedef struct {
      logic [2:0] v;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic wake = 1'b0;
   logic sys_rst, pwr_en, off;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   event sample_ev;

   pmu_bus pmb_if ();

   boa_pmu_sequencer #(
      .RST_CYCLES  (4),
      .SHDN_CYCLES (3),
      .PWRUP_CYCLES(5)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pmb    (pmb_if),
      .wake   (wake),
      .sys_rst(sys_rst),
      .pwr_en (pwr_en),
      .off    (off)
   );

   always #5 clk = ~clk;

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk or sample_ev);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({sys_rst, pwr_en, off} !== e.v) begin
               n_bad++;
               $display("FAIL %s: sys_rst/pwr_en/off got %b%b%b expected %b", e.name, sys_rst, pwr_en, off, e.v);
            end
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic w, input logic [2:0] e, input string n);
      exp_t x;
      @(negedge clk);
      pmb_if.rst  = r;
      pmb_if.shdn = s;
      wake        = w;
      x.v    = e;
      x.name = n;
      exp_q.push_back(x);
      @(posedge clk);
   endtask

   task automatic expect_now(input logic [2:0] e, input string n);
      exp_t x;
      x.v    = e;
      x.name = n;
      exp_q.push_back(x);
      -> sample_ev;
      #2;
   endtask

   initial begin
      pmb_if.rst  = 1'b0;
      pmb_if.shdn = 1'b0;
      #1 rst = 1'b1;
      #1 expect_now(3'b110, "por_async");
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b110, $sformatf("por_hold%0d", i));
      step(0, 0, 0, 3'b010, "por_run");
      step(0, 0, 1, 3'b010, "wake_in_run");
      step(1, 0, 0, 3'b110, "rreq_enter");
      step(0, 0, 0, 3'b110, "rreq_c2");
      step(0, 0, 0, 3'b110, "rreq_c3");
      step(1, 0, 0, 3'b110, "rreq_repulse");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b110, $sformatf("rreq_ext%0d", i));
      step(0, 0, 0, 3'b010, "rreq_run");
      step(0, 1, 0, 3'b110, "shdn_enter");
      step(1, 0, 0, 3'b110, "shdn_rst_ign");
      step(0, 0, 0, 3'b110, "shdn_last");
      step(0, 0, 0, 3'b101, "shdn_off");
      step(1, 1, 0, 3'b101, "off_pmb_ign");
      step(0, 0, 0, 3'b101, "off_hold");
      step(0, 0, 1, 3'b110, "wake_pwrup");
      for (int i = 0; i < 8; i++) step(0, 0, 0, 3'b110, $sformatf("wake_hold%0d", i));
      step(0, 0, 0, 3'b010, "wake_run");
      step(1, 1, 0, 3'b110, "both_enter");
      step(0, 0, 0, 3'b110, "both_c2");
      step(0, 0, 0, 3'b110, "both_c3");
      step(0, 0, 0, 3'b101, "both_off");
      @(negedge clk);
      #2 rst = 1'b1;
      #1 expect_now(3'b110, "async_off");
      step(0, 0, 0, 3'b110, "async_hold");
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b110, $sformatf("rel_hold%0d", i));
      step(0, 0, 0, 3'b010, "rel_run");
      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
